// File: rtl/if_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input and the decode-side valid/ready port.
// The master side belongs to the fetch stage; the slave side is its environment.
interface if_fetch_if;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    modport master (
        output imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out,
        input  imem_rvalid_in, imem_rdata_in, redirect_in, redirect_pc_in, instr_ready_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out,
        output imem_rvalid_in, imem_rdata_in, redirect_in, redirect_pc_in, instr_ready_in
    );
endinterface

// File: rtl/if_fetch.sv
// RV32I instruction fetch: one outstanding word read, single-entry output register to decode,
// and redirect handling that flushes the output slot and drops any stale in-flight response.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    if_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;

    logic        slot_free;
    logic [31:0] redirect_tgt;
    logic [31:0] pc_inc;

    assign slot_free    = !valid_q || bus.instr_ready_in;
    assign redirect_tgt = bus.redirect_pc_in & ~32'h3;
    assign pc_inc       = pc_q + 32'd4;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        req_d    = 1'b0;
        addr_d   = addr_q;

        if (valid_q && bus.instr_ready_in)
            valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.redirect_in) begin
                    pc_d = redirect_tgt;
                end else if (slot_free) begin
                    // Request/address are registered so they are clean Moore outputs in FETCH.
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            FETCH: begin
                state_d = WAIT;
                if (bus.redirect_in) begin
                    drop_d = 1'b1;
                    pc_d   = redirect_tgt;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid_in) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q && !bus.redirect_in) begin
                        instr_d  = bus.imem_rdata_in;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_inc;
                    end else if (bus.redirect_in) begin
                        pc_d = redirect_tgt;
                    end
                end else if (bus.redirect_in) begin
                    drop_d = 1'b1;
                    pc_d   = redirect_tgt;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over both consume and load.
        if (bus.redirect_in)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC_ALIGNED;
            drop_q   <= 1'b0;
            valid_q  <= 1'b0;
            instr_q  <= 32'd0;
            pc_out_q <= 32'd0;
            req_q    <= 1'b0;
            addr_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
        end
    end

    assign bus.imem_req_out    = req_q;
    assign bus.imem_addr_out   = addr_q;
    assign bus.instr_valid_out = valid_q;
    assign bus.instr_out       = instr_q;
    assign bus.pc_out          = pc_out_q;
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed timing scenarios plus a randomized run checked against an
// architectural model (program-order PC stream, redirects, address-keyed memory contents).
`timescale 1ns/1ps
module tb_if_fetch;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_w_n;

    always #5 clk = ~clk;

    if_fetch_if bus ();
    if_fetch_if bus_w ();

    if_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk  (clk),
        .rst_n(rst_w_n),
        .bus  (bus_w.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic idle_inputs();
        bus.imem_rvalid_in = 1'b0;
        bus.imem_rdata_in  = 32'd0;
        bus.redirect_in    = 1'b0;
        bus.redirect_pc_in = 32'd0;
        bus.instr_ready_in = 1'b1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        check_eq("rst_req",   bus.imem_req_out,    32'd0);
        check_eq("rst_addr",  bus.imem_addr_out,   32'd0);
        check_eq("rst_valid", bus.instr_valid_out, 32'd0);
        check_eq("rst_instr", bus.instr_out,       32'd0);
        check_eq("rst_pc",    bus.pc_out,          32'd0);
        rst_n = 1'b1;
    endtask

    task automatic t_reset_fetch(input int stall);
        reset_dut();
        @(negedge clk);
        check_eq("c1_req",  bus.imem_req_out,  32'd1);
        check_eq("c1_addr", bus.imem_addr_out, 32'h100);
        @(negedge clk);
        check_eq("c2_req", bus.imem_req_out, 32'd0);
        bus.imem_rvalid_in = 1'b1;
        bus.imem_rdata_in  = 32'h0000_0093;
        @(negedge clk);
        bus.imem_rvalid_in = 1'b0;
        check_eq("c3_valid", bus.instr_valid_out, 32'd1);
        check_eq("c3_instr", bus.instr_out,       32'h93);
        check_eq("c3_pc",    bus.pc_out,          32'h100);
        bus.instr_ready_in = (stall == 0);
        for (int i = 1; i < stall; i++) begin
            @(negedge clk);
            check_eq("stall_req",   bus.imem_req_out,    32'd0);
            check_eq("stall_valid", bus.instr_valid_out, 32'd1);
            check_eq("stall_instr", bus.instr_out,       32'h93);
            check_eq("stall_pc",    bus.pc_out,          32'h100);
        end
        if (stall > 0) begin
            @(negedge clk);
            check_eq("stall_end_valid", bus.instr_valid_out, 32'd1);
            bus.instr_ready_in = 1'b1;
        end
        @(negedge clk);
        check_eq("next_req",   bus.imem_req_out,    32'd1);
        check_eq("next_addr",  bus.imem_addr_out,   32'h104);
        check_eq("next_valid", bus.instr_valid_out, 32'd0);
    endtask

    task automatic t_redirect_wait();
        reset_dut();
        @(negedge clk);
        check_eq("rw_req", bus.imem_req_out, 32'd1);
        @(negedge clk);
        bus.redirect_in    = 1'b1;
        bus.redirect_pc_in = 32'h0000_2003;
        @(negedge clk);
        bus.redirect_in = 1'b0;
        check_eq("rw_valid3", bus.instr_valid_out, 32'd0);
        @(negedge clk);
        bus.imem_rvalid_in = 1'b1;
        bus.imem_rdata_in  = 32'hBAD0_0001;
        @(negedge clk);
        bus.imem_rvalid_in = 1'b0;
        check_eq("rw_valid5", bus.instr_valid_out, 32'd0);
        check_eq("rw_req5",   bus.imem_req_out,    32'd0);
        @(negedge clk);
        check_eq("rw_req6",  bus.imem_req_out,  32'd1);
        check_eq("rw_addr6", bus.imem_addr_out, 32'h2000);
        @(negedge clk);
        @(negedge clk);
        check_eq("rw_valid8", bus.instr_valid_out, 32'd0);
        @(negedge clk);
        bus.imem_rvalid_in = 1'b1;
        bus.imem_rdata_in  = 32'h0020_0513;
        @(negedge clk);
        bus.imem_rvalid_in = 1'b0;
        check_eq("rw_valid10", bus.instr_valid_out, 32'd1);
        check_eq("rw_instr10", bus.instr_out,       32'h0020_0513);
        check_eq("rw_pc10",    bus.pc_out,          32'h2000);
    endtask

    task automatic t_redirect_rvalid();
        reset_dut();
        @(negedge clk);
        check_eq("rr_req1", bus.imem_req_out, 32'd1);
        @(negedge clk);
        bus.imem_rvalid_in = 1'b1;
        bus.imem_rdata_in  = 32'hBAD0_0002;
        bus.redirect_in    = 1'b1;
        bus.redirect_pc_in = 32'h0000_3000;
        @(negedge clk);
        bus.imem_rvalid_in = 1'b0;
        bus.redirect_in    = 1'b0;
        check_eq("rr_valid3", bus.instr_valid_out, 32'd0);
        check_eq("rr_req3",   bus.imem_req_out,    32'd0);
        @(negedge clk);
        check_eq("rr_req4",   bus.imem_req_out,    32'd1);
        check_eq("rr_addr4",  bus.imem_addr_out,   32'h3000);
        check_eq("rr_valid4", bus.instr_valid_out, 32'd0);
    endtask

    task automatic t_wrap_flush();
        @(negedge clk);
        rst_w_n = 1'b0;
        @(negedge clk);
        check_eq("w_rst_valid", bus_w.instr_valid_out, 32'd0);
        rst_w_n = 1'b1;
        @(negedge clk);
        check_eq("w_req1",  bus_w.imem_req_out,  32'd1);
        check_eq("w_addr1", bus_w.imem_addr_out, 32'hFFFF_FFFC);
        @(negedge clk);
        bus_w.imem_rvalid_in = 1'b1;
        bus_w.imem_rdata_in  = 32'h0000_0011;
        @(negedge clk);
        bus_w.imem_rvalid_in = 1'b0;
        check_eq("w_valid3", bus_w.instr_valid_out, 32'd1);
        check_eq("w_pc3",    bus_w.pc_out,          32'hFFFF_FFFC);
        check_eq("w_instr3", bus_w.instr_out,       32'h11);
        @(negedge clk);
        check_eq("w_req4",  bus_w.imem_req_out,  32'd1);
        check_eq("w_addr4", bus_w.imem_addr_out, 32'h0);
        @(negedge clk);
        bus_w.imem_rvalid_in = 1'b1;
        bus_w.imem_rdata_in  = 32'h0000_0022;
        @(negedge clk);
        bus_w.imem_rvalid_in = 1'b0;
        check_eq("w_valid6", bus_w.instr_valid_out, 32'd1);
        check_eq("w_pc6",    bus_w.pc_out,          32'h0);
        bus_w.instr_ready_in = 1'b0;
        bus_w.redirect_in    = 1'b1;
        bus_w.redirect_pc_in = 32'h0000_0040;
        @(negedge clk);
        bus_w.redirect_in = 1'b0;
        check_eq("w_flush_valid", bus_w.instr_valid_out, 32'd0);
    endtask

    task automatic t_mid_reset();
        reset_dut();
        @(negedge clk);
        check_eq("mr_req1", bus.imem_req_out, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mr_req",   bus.imem_req_out,    32'd0);
        check_eq("mr_addr",  bus.imem_addr_out,   32'd0);
        check_eq("mr_valid", bus.instr_valid_out, 32'd0);
        check_eq("mr_instr", bus.instr_out,       32'd0);
        check_eq("mr_pc",    bus.pc_out,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_rvalid_in = 1'b1;
        bus.imem_rdata_in  = 32'hBAD0_0003;
        @(negedge clk);
        bus.imem_rvalid_in = 1'b0;
        check_eq("mr_restart_req",   bus.imem_req_out,    32'd1);
        check_eq("mr_restart_addr",  bus.imem_addr_out,   32'h100);
        check_eq("mr_restart_valid", bus.instr_valid_out, 32'd0);
        @(negedge clk);
        check_eq("mr_stale_valid", bus.instr_valid_out, 32'd0);
    endtask

    logic [31:0] exp_pc, mem_addr, prev_instr, prev_pc;
    int          mem_cnt, deliveries;
    logic        hold, clr, redir, redir_prev, ready, got_req;

    task automatic t_random(input int cycles);
        reset_dut();
        exp_pc = 32'h100; mem_cnt = 0; deliveries = 0;
        hold = 1'b0; clr = 1'b0; redir_prev = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (hold) begin
                check_eq("hold_valid", bus.instr_valid_out, 32'd1);
                check_eq("hold_instr", bus.instr_out,       prev_instr);
                check_eq("hold_pc",    bus.pc_out,          prev_pc);
            end
            if (clr)
                check_eq("clear_valid", bus.instr_valid_out, 32'd0);
            got_req = bus.imem_req_out;
            if (got_req) begin
                check_eq("one_outstanding", mem_cnt, 32'd0);
                check_eq("req_align", {30'd0, bus.imem_addr_out[1:0]}, 32'd0);
            end
            // Memory: respond after 1..3 cycles; occasionally emit spurious data when idle.
            bus.imem_rvalid_in = 1'b0;
            bus.imem_rdata_in  = $urandom;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.imem_rvalid_in = 1'b1;
                    bus.imem_rdata_in  = mem_word(mem_addr);
                end
            end else if ($urandom_range(0, 9) == 0) begin
                bus.imem_rvalid_in = 1'b1;
            end
            if (got_req) begin
                mem_cnt  = $urandom_range(1, 3);
                mem_addr = bus.imem_addr_out;
            end
            ready = ($urandom_range(0, 3) != 0);
            redir = !redir_prev && ($urandom_range(0, 19) == 0);
            bus.instr_ready_in = ready;
            bus.redirect_in    = redir;
            bus.redirect_pc_in = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                             : ($urandom & 32'h0000_FFFF);
            if (bus.instr_valid_out && ready && !redir) begin
                check_eq("dlv_pc",    bus.pc_out,    exp_pc);
                check_eq("dlv_instr", bus.instr_out, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            if (redir)
                exp_pc = bus.redirect_pc_in & ~32'h3;
            hold       = bus.instr_valid_out && !ready && !redir;
            clr        = (bus.instr_valid_out && ready) || redir;
            prev_instr = bus.instr_out;
            prev_pc    = bus.pc_out;
            redir_prev = redir;
        end
        @(negedge clk);
        idle_inputs();
        check_eq("progress", (deliveries > 50) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        rst_w_n = 1'b0;
        idle_inputs();
        bus_w.imem_rvalid_in = 1'b0;
        bus_w.imem_rdata_in  = 32'd0;
        bus_w.redirect_in    = 1'b0;
        bus_w.redirect_pc_in = 32'd0;
        bus_w.instr_ready_in = 1'b1;

        t_reset_fetch(0);
        t_reset_fetch(5);
        t_redirect_wait();
        t_redirect_rvalid();
        t_wrap_flush();
        t_mid_reset();
        t_random(3000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage of the RV32I core. Holds the program counter, issues one word-aligned read at a time to instruction memory, and presents each returned instruction with its PC to the decode stage through a single-entry valid/ready output register. Decode and the immediate generator consume `instr_out`. Branch/jump resolution redirects the PC through `redirect_in` and flushes any stale fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] are ignored and treated as 0.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `imem_req_out`, output, 1: read request. Memory accepts it in the same cycle.
- `imem_addr_out`, output, 32: read address. Valid while `imem_req_out`=1.
- `imem_rvalid_in`, input, 1: read data valid. Arrives at least 1 cycle after the request cycle.
- `imem_rdata_in`, input, 32: instruction word. Sampled when `imem_rvalid_in`=1.
- `redirect_in`, input, 1: single-cycle pulse that changes the fetch PC.
- `redirect_pc_in`, input, 32: target PC. Bits [1:0] are forced to 0.
- `instr_valid_out`, output, 1: `instr_out`/`pc_out` hold an unconsumed instruction.
- `instr_ready_in`, input, 1: decode accepts the instruction this cycle.
- `instr_out`, output, 32: fetched instruction.
- `pc_out`, output, 32: address of `instr_out`.

## Operation
- **Registered state:**
  - `pc_q` (32 bits): next address to fetch.
  - FSM: IDLE, FETCH, WAIT.
  - `drop_q`: discard the in-flight response.
  - Output register: `instr_valid_out`, `instr_out`, `pc_out`.
- **Reset values:** `pc_q`=RESET_PC with bits [1:0]=0; state=IDLE; `drop_q`=0; `instr_valid_out`=0; `instr_out`=0; `pc_out`=0; `imem_req_out`=0; `imem_addr_out`=0.
- **Slot free:** `slot_free` = !`instr_valid_out` || `instr_ready_in`.
- **Consume:** when `instr_valid_out` && `instr_ready_in`, `instr_valid_out` clears at the next edge. A new instruction can never load in that same edge.
- **IDLE:**
  - `redirect_in`=1 → stay IDLE; `pc_q`←redirect target.
  - Otherwise, if `slot_free` → FETCH.
  - Otherwise stay IDLE.
- **FETCH:** `imem_req_out`=1 and `imem_addr_out`=`pc_q`, both Moore outputs driven from registers. Next state is WAIT.
  - `redirect_in` in this cycle: the request is still issued. Set `drop_q`=1 and `pc_q`←target.
- **WAIT:**
  - `imem_rvalid_in`=1 and `drop_q`=0 and `redirect_in`=0: load `instr_out`←`imem_rdata_in`, `pc_out`←`pc_q`, `instr_valid_out`←1; `pc_q`←`pc_q`+4; go IDLE.
  - `imem_rvalid_in`=1 and (`drop_q`=1 or `redirect_in`=1): discard the data; clear `drop_q`; go IDLE. If `redirect_in`=1, `pc_q`←target.
  - `imem_rvalid_in`=0 and `redirect_in`=1: set `drop_q`=1, `pc_q`←target, stay WAIT.
- **Flush:** `redirect_in`=1 in any state clears `instr_valid_out` at the next edge. Flush takes priority over consume.
- **PC arithmetic:** modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000. `pc_q`[1:0] is always 0.
- **Ordering:** at most one request is outstanding. A request is issued only when the output slot is free or being emptied, so a response is always loaded into an empty slot.
- **Spurious data:** `imem_rvalid_in` outside WAIT is ignored.
- **Mid-operation reset:** `rst_n` low in any state returns everything to the reset values immediately. A later `imem_rvalid_in` lands in IDLE and is ignored.

## Timing
- `rst_n` released before edge 0:
  - Edge 0: IDLE→FETCH.
  - Cycle 1: request at RESET_PC.
  - With 1-cycle memory, `imem_rvalid_in` arrives in cycle 2 and `instr_valid_out`=1 in cycle 3.
- Steady state with `instr_ready_in`=1 and memory latency L: one instruction per L+2 cycles (FETCH, L×WAIT, IDLE).
- Redirect in IDLE at cycle t: request to the new target in cycle t+2.
- Redirect in WAIT at cycle t, response at cycle r>t: r+1 IDLE, r+2 request to the new target.
- Decode stall: while `instr_valid_out`=1 and `instr_ready_in`=0, the FSM stays in IDLE and the outputs hold stable.

## Test plan
1. **Reset fetch:** RESET_PC=32'h0000_0100, 1-cycle memory returning 32'h0000_0093, ready=1 → request addr 0x100 in cycle 1; `instr_out`=0x00000093 and `pc_out`=0x100 valid in cycle 3; next request addr 0x104.
2. **Decode stall:** hold ready=0 for 5 cycles after the first instruction → no new request, outputs stable. Ready=1 → the following cycle is FETCH with addr 0x104.
3. **Redirect in WAIT:** 3-cycle memory, redirect to 32'h0000_2003 one cycle after the request → the old response is discarded (`instr_valid_out` stays 0); the next request is addr 0x2000, and the instruction returned for it appears with `pc_out`=0x2000.
4. **Redirect coincident with rvalid:** the response is discarded, `instr_valid_out` stays 0, and the next request goes to the target.
5. **Wrap and flush:** RESET_PC=32'hFFFF_FFFC → the second request is addr 0x0. A redirect while `instr_valid_out`=1 and ready=0 → valid clears next cycle.
6. **Mid-operation reset:** assert `rst_n`=0 in WAIT → all outputs zero immediately; a subsequent rvalid is ignored; after release, fetch restarts at RESET_PC.
